// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller.
// Sequences the oversampling data sampler, tracks the position within the frame,
// deserializes data LSB-first, and flags start glitches, parity errors and stop errors.
// Optional build macro UART_RX_ERR_CNT_EN adds an 8-bit saturating error counter port err_cnt.
module uart_rx_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic [5:0]        Prescale,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              sampled_bit,
    input  logic              bit_ready,
    output logic              data_samp_en,
    output logic [4:0]        edge_cnt,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              strt_glitch,
    output logic              busy
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [4:0]        edge_max_d;
    logic [4:0]        edge_max_q;
    logic              par_en_q;
    logic              par_typ_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic [DATA_W-1:0] shift_reg;
    logic              par_fail;
    logic              wrap;
    logic              glitch_d;
    logic              stp_err_d;
    logic              par_err_d;
    logic              valid_d;

    // Map the oversampling ratio to the last edge index; unsupported ratios fall back to 8.
    always_comb begin
        case (Prescale)
            6'd16:   edge_max_d = 5'd15;
            6'd32:   edge_max_d = 5'd31;
            default: edge_max_d = 5'd7;
        endcase
    end

    assign wrap        = (state != IDLE) && (edge_cnt == edge_max_q);
    assign bit_cnt_nxt = (state == DATA && bit_ready) ? bit_cnt + CNT_W'(1) : bit_cnt;

    // Frame configuration is captured only while idle so mid-frame changes have no effect.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_max_q <= 5'd7;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
        end else if (state == IDLE) begin
            edge_max_q <= edge_max_d;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a bit arriving together with a wrap is consumed before the transition.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!RX_IN) next_state = START;
            end
            START: begin
                if (bit_ready && sampled_bit) next_state = IDLE;
                else if (wrap)                next_state = DATA;
            end
            DATA: begin
                if (wrap && (bit_cnt_nxt >= CNT_W'(DATA_W)))
                    next_state = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (wrap) next_state = STOP;
            end
            STOP: begin
                if (bit_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode: sampler enable, busy and the status events that get registered below.
    always_comb begin
        busy         = (state != IDLE);
        data_samp_en = (state != IDLE);
        glitch_d     = (state == START) && bit_ready && sampled_bit;
        stp_err_d    = (state == STOP) && bit_ready && !sampled_bit;
        par_err_d    = (state == STOP) && bit_ready && sampled_bit && par_fail;
        valid_d      = (state == STOP) && bit_ready && sampled_bit && !par_fail;
    end

    // Edge counter, bit counter, shift register and parity-fail flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt  <= 5'd0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_fail  <= 1'b0;
        end else begin
            if (state == IDLE || next_state == IDLE) edge_cnt <= 5'd0;
            else if (wrap)                           edge_cnt <= 5'd0;
            else                                     edge_cnt <= edge_cnt + 5'd1;

            if (state == IDLE && next_state == START) begin
                bit_cnt  <= '0;
                par_fail <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt_nxt;
                if (state == PARITY && bit_ready &&
                    (sampled_bit != ((^shift_reg) ^ par_typ_q)))
                    par_fail <= 1'b1;
            end

            if (state == DATA && bit_ready)
                shift_reg <= {sampled_bit, shift_reg[DATA_W-1:1]};
        end
    end

    // Registered one-cycle status pulses; P_DATA only changes on a good frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
            P_DATA      <= '0;
        end else begin
            data_valid  <= valid_d;
            par_err     <= par_err_d;
            stp_err     <= stp_err_d;
            strt_glitch <= glitch_d;
            if (valid_d) P_DATA <= shift_reg;
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    // Saturating count of every error pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_cnt <= 8'd0;
        end else if ((par_err || stp_err || strt_glitch) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl.
// Includes a simple mid-bit sampler model and a pulse monitor.
// Build with UART_RX_ERR_CNT_EN to also check err_cnt.
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       bit_ready;
    logic       data_samp_en;
    logic [4:0] edge_cnt;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       strt_glitch;
    logic       busy;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int presc = 8;
    int checkCount = 0;
    int passCount = 0;

    int dvCount = 0;
    int parCount = 0;
    int stpCount = 0;
    int glCount = 0;
    int badBusy = 0;
    logic [7:0] dvData [0:15];

    uart_rx_ctrl #(.DATA_W(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_IN(RX_IN),
        .Prescale(Prescale),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .sampled_bit(sampled_bit),
        .bit_ready(bit_ready),
        .data_samp_en(data_samp_en),
        .edge_cnt(edge_cnt),
        .P_DATA(P_DATA),
        .data_valid(data_valid),
        .par_err(par_err),
        .stp_err(stp_err),
        .strt_glitch(strt_glitch),
        .busy(busy)
`ifdef UART_RX_ERR_CNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Sampler model: one strobe per bit at the middle edge index, carrying the line value.
    always @(negedge CLK) begin
        bit_ready   = data_samp_en && (edge_cnt == 5'(presc / 2));
        sampled_bit = RX_IN;
    end

    // Pulse monitor: counts status pulses, records accepted bytes, flags busy during a pulse.
    always @(negedge CLK) begin
        if (data_valid) begin
            if (dvCount < 16) dvData[dvCount] = P_DATA;
            dvCount++;
        end
        if (par_err)     parCount++;
        if (stp_err)     stpCount++;
        if (strt_glitch) glCount++;
        if ((data_valid || par_err || stp_err || strt_glitch) && busy) badBusy++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        else
            passCount++;
    endtask

    task automatic sendBit(input logic b);
        @(posedge CLK);
        #1;
        RX_IN = b;
        repeat (presc - 1) @(posedge CLK);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic hasPar,
                                 input logic parBit, input logic stopBit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(data[i]);
        if (hasPar) sendBit(parBit);
        sendBit(stopBit);
    endtask

    task automatic idleLine(input int n);
        @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
    endtask

    task automatic configure(input int ps, input logic pe, input logic pt);
        @(posedge CLK);
        #1;
        presc    = ps;
        Prescale = 6'(ps);
        PAR_EN   = pe;
        PAR_TYP  = pt;
    endtask

    initial begin
        int dv0, par0, stp0, gl0;

        RST      = 1'b1;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_data_valid", data_valid, 0);
        checkOutput("reset_P_DATA", P_DATA, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_edge_cnt", edge_cnt, 0);
        checkOutput("reset_samp_en", data_samp_en, 0);
        checkOutput("reset_err_pulses", {par_err, stp_err, strt_glitch}, 0);
`ifdef UART_RX_ERR_CNT_EN
        checkOutput("reset_err_cnt", err_cnt, 0);
`endif
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idleLine(4);

        $display("[TB] good frame 0xA5, Prescale 8, even parity");
        configure(8, 1'b1, 1'b0);
        dv0 = dvCount; par0 = parCount; stp0 = stpCount; gl0 = glCount;
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1);
        idleLine(20);
        checkOutput("a5_valid_count", dvCount - dv0, 1);
        checkOutput("a5_P_DATA", P_DATA, 8'hA5);
        checkOutput("a5_par_err", parCount - par0, 0);
        checkOutput("a5_stp_err", stpCount - stp0, 0);
        checkOutput("a5_glitch", glCount - gl0, 0);
        checkOutput("a5_busy_idle", busy, 0);

        $display("[TB] same frame with odd parity selected");
        configure(8, 1'b1, 1'b1);
        dv0 = dvCount; par0 = parCount; stp0 = stpCount;
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1);
        idleLine(20);
        checkOutput("odd_par_err", parCount - par0, 1);
        checkOutput("odd_valid_count", dvCount - dv0, 0);
        checkOutput("odd_stp_err", stpCount - stp0, 0);
        checkOutput("odd_P_DATA_held", P_DATA, 8'hA5);
`ifdef UART_RX_ERR_CNT_EN
        checkOutput("odd_err_cnt", err_cnt, 1);
`endif

        $display("[TB] start glitch at Prescale 16, then frame 0x5A");
        configure(16, 1'b0, 1'b0);
        dv0 = dvCount; gl0 = glCount;
        @(posedge CLK);
        #1;
        RX_IN = 1'b0;
        @(negedge CLK);
        checkOutput("detect_busy_before", busy, 0);
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("detect_busy", busy, 1);
        checkOutput("detect_edge0", edge_cnt, 0);
        checkOutput("detect_samp_en", data_samp_en, 1);
        @(negedge CLK);
        checkOutput("detect_edge1", edge_cnt, 1);
        @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        repeat (40) @(posedge CLK);
        checkOutput("glitch_count", glCount - gl0, 1);
        checkOutput("glitch_no_valid", dvCount - dv0, 0);
        checkOutput("glitch_busy_idle", busy, 0);
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1);
        idleLine(40);
        checkOutput("after_glitch_valid", dvCount - dv0, 1);
        checkOutput("after_glitch_P_DATA", P_DATA, 8'h5A);
`ifdef UART_RX_ERR_CNT_EN
        checkOutput("glitch_err_cnt", err_cnt, 2);
`endif

        $display("[TB] stop error on 0x0F, Prescale 8, no parity");
        configure(8, 1'b0, 1'b0);
        dv0 = dvCount; stp0 = stpCount; par0 = parCount;
        applyStimulus(8'h0F, 1'b0, 1'b0, 1'b0);
        idleLine(30);
        checkOutput("stop_err_count", stpCount - stp0, 1);
        checkOutput("stop_no_valid", dvCount - dv0, 0);
        checkOutput("stop_no_par_err", parCount - par0, 0);
        checkOutput("stop_P_DATA_held", P_DATA, 8'h5A);

        $display("[TB] back-to-back 0x3C, 0xC3 at Prescale 32");
        configure(32, 1'b0, 1'b0);
        dv0 = dvCount; stp0 = stpCount; gl0 = glCount;
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hC3, 1'b0, 1'b0, 1'b1);
        idleLine(60);
        checkOutput("b2b_valid_count", dvCount - dv0, 2);
        checkOutput("b2b_first", dvData[dv0], 8'h3C);
        checkOutput("b2b_second", dvData[dv0 + 1], 8'hC3);
        checkOutput("b2b_P_DATA", P_DATA, 8'hC3);
        checkOutput("b2b_no_errors", (stpCount - stp0) + (glCount - gl0), 0);

        $display("[TB] reset during data bit 4 of 0xFF, then 0x81");
        configure(8, 1'b0, 1'b0);
        dv0 = dvCount; par0 = parCount; stp0 = stpCount; gl0 = glCount;
        fork
            applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1);
            begin
                repeat (44) @(posedge CLK);
                #2;
                RST = 1'b1;
                repeat (2) @(posedge CLK);
                #2;
                RST = 1'b0;
            end
        join
        idleLine(20);
        checkOutput("rst_no_valid", dvCount - dv0, 0);
        checkOutput("rst_no_errors", (parCount - par0) + (stpCount - stp0) + (glCount - gl0), 0);
        checkOutput("rst_busy_idle", busy, 0);
        checkOutput("rst_P_DATA_cleared", P_DATA, 0);
        applyStimulus(8'h81, 1'b0, 1'b0, 1'b1);
        idleLine(20);
        checkOutput("post_rst_valid", dvCount - dv0, 1);
        checkOutput("post_rst_P_DATA", P_DATA, 8'h81);
`ifdef UART_RX_ERR_CNT_EN
        checkOutput("post_rst_err_cnt", err_cnt, 0);
`endif

        checkOutput("busy_low_at_pulses", badBusy, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
